arbitro1_rr: RTL

//  Upstream stage of arbitro2. Round-robin arbiter that drains four input FIFOs
//  (show-ahead heads) into the single middle FIFO that arbitro2 pops.
//  Per-port burst quantum. Registered 1-cycle data path (muxout/push).

---
 rtl/arbitro1_rr.sv | 118 +++++++++++
 1 files changed

// File: rtl/arbitro1_rr.sv
// Round-robin arbiter with a per-port burst quantum. It drains four show-ahead
// input FIFOs into one middle FIFO through a registered one-cycle data path.
module arbitro1_rr #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned BURST  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic [DATA_W-1:0] data3,
   input  logic [3:0]        emptyFIFO,
   input  logic              almost_fullFIFO,
   output logic [3:0]        pop,
   output logic              push,
   output logic [DATA_W-1:0] muxout,
   output logic [1:0]        grant
);

   localparam int unsigned CNT_W = (BURST < 1) ? 1 : $clog2(BURST + 1);
   localparam int unsigned NPORT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      STALL = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          grant_q, grant_d;
   logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic                push_q, push_d;
   logic [DATA_W-1:0]   muxout_q, muxout_d;

   logic [3:0]          eligible;
   logic [1:0]          sel;
   logic [1:0]          cand;
   logic                found;
   logic [DATA_W-1:0]   data_arr [NPORT];

   assign eligible    = ~emptyFIFO;
   assign data_arr[0] = data0;
   assign data_arr[1] = data1;
   assign data_arr[2] = data2;
   assign data_arr[3] = data3;

   // Next-state: pick the port to pop this cycle and update grant/quantum.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      burst_cnt_d = burst_cnt_q;
      pop         = 4'b0000;
      sel         = grant_q;
      cand        = grant_q;
      found       = 1'b0;

      if (!reset) begin
         pop = 4'b0000;
      end else if (almost_fullFIFO) begin
         state_d = STALL;
      end else if (eligible[grant_q] && (burst_cnt_q < CNT_W'(BURST))) begin
         sel         = grant_q;
         pop         = 4'b0001 << grant_q;
         burst_cnt_d = burst_cnt_q + CNT_W'(1);
         state_d     = SERVE;
      end else begin
         // Scan grant+1 .. grant+4 so the current holder comes last.
         for (int unsigned k = 1; k <= NPORT; k++) begin
            cand = grant_q + 2'(k);
            if (!found && eligible[cand]) begin
               found = 1'b1;
               sel   = cand;
            end
         end
         if (found) begin
            pop         = 4'b0001 << sel;
            grant_d     = sel;
            burst_cnt_d = CNT_W'(1);
            state_d     = SERVE;
         end else begin
            burst_cnt_d = '0;
            state_d     = IDLE;
         end
      end
   end

   // Data path: a popped head word is pushed on the following edge.
   always_comb begin
      push_d   = |pop;
      muxout_d = muxout_q;
      if (|pop) begin
         muxout_d = data_arr[sel];
      end
   end

   // State and output registers; reset discards any in-flight word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         grant_q     <= 2'd0;
         burst_cnt_q <= '0;
         push_q      <= 1'b0;
         muxout_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         burst_cnt_q <= burst_cnt_d;
         push_q      <= push_d;
         muxout_q    <= muxout_d;
      end
   end

   assign push   = push_q;
   assign muxout = muxout_q;
   assign grant  = grant_q;

endmodule
